core_mem_arbiter: RTL and testbench

Parametrised single-port SRAM front end for the core level. It owns one `sram` instance and arbitrates it cycle by cycle between a host/testbench port and a compute-engine (corelet) port. Both ports use a request/grant handshake with tagged read return. A host-lock input reproduces the old static testbench-select behaviour. One instance is placed per memory (input/weight SRAM, output SRAM), with width and depth set per instance.

---
 rtl/core_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_core_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Single-port SRAM front end that arbitrates a host port and an engine port cycle by cycle.
// Optional feature: define MEM_ARB_RR_EN for round-robin conflict resolution (default: host priority).

module sram #(
    parameter int unsigned DATA_BW = 32,
    parameter int unsigned ROWS    = 108,
    parameter int unsigned ADDR_BW = 7
) (
    input  logic               clk,
    input  logic               cen,
    input  logic               wen,
    input  logic [ADDR_BW-1:0] a,
    input  logic [DATA_BW-1:0] d,
    output logic [DATA_BW-1:0] q
);
    logic [DATA_BW-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) mem[a] <= d;
            else      q      <= mem[a];
        end
    end
endmodule

module core_mem_arbiter #(
    parameter int unsigned DATA_BW = 32,
    parameter int unsigned ROWS    = 108,
    parameter int unsigned ADDR_BW = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               host_lock,
    input  logic               h_req,
    input  logic               h_we,
    input  logic [ADDR_BW-1:0] h_addr,
    input  logic [DATA_BW-1:0] h_wdata,
    output logic               h_gnt,
    output logic               h_rvalid,
    output logic [DATA_BW-1:0] h_rdata,
    input  logic               e_req,
    input  logic               e_we,
    input  logic [ADDR_BW-1:0] e_addr,
    input  logic [DATA_BW-1:0] e_wdata,
    output logic               e_gnt,
    output logic               e_rvalid,
    output logic [DATA_BW-1:0] e_rdata,
    output logic               addr_err,
    output logic [15:0]        e_stall_cnt
);
    typedef enum logic {PORT_HOST, PORT_ENGINE} port_t;

    // One extra bit so ROWS == 2**ADDR_BW still compares correctly.
    localparam logic [ADDR_BW:0] ROWS_LIM = (ADDR_BW+1)'(ROWS);

    logic               h_elig, e_elig, host_wins, any_gnt, in_range;
    logic               sel_we;
    logic [ADDR_BW-1:0] sel_addr;
    logic [DATA_BW-1:0] sel_wdata;
    logic               cen, wen;
    logic [DATA_BW-1:0] sram_q, rd_data;
    logic               rd_pend, rd_oob;
    port_t              rd_tag;
    logic [DATA_BW-1:0] h_hold, e_hold;

`ifdef MEM_ARB_RR_EN
    port_t last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        last_grant <= PORT_ENGINE;
        else if (any_gnt) last_grant <= e_gnt ? PORT_ENGINE : PORT_HOST;
    end

    assign host_wins = (last_grant == PORT_ENGINE);
`else
    assign host_wins = 1'b1;
`endif

    always_comb begin
        h_elig    = h_req;
        e_elig    = e_req & ~host_lock;
        h_gnt     = h_elig & (~e_elig | host_wins);
        e_gnt     = e_elig & ~h_gnt;
        any_gnt   = h_gnt | e_gnt;
        sel_we    = e_gnt ? e_we    : h_we;
        sel_addr  = e_gnt ? e_addr  : h_addr;
        sel_wdata = e_gnt ? e_wdata : h_wdata;
        in_range  = {1'b0, sel_addr} < ROWS_LIM;
        // Out-of-range accesses never reach the macro; reads are answered with zero.
        cen       = ~(any_gnt & in_range);
        wen       = ~sel_we;
    end

    sram #(
        .DATA_BW(DATA_BW),
        .ROWS   (ROWS),
        .ADDR_BW(ADDR_BW)
    ) u_sram (
        .clk(clk),
        .cen(cen),
        .wen(wen),
        .a  (sel_addr),
        .d  (sel_wdata),
        .q  (sram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_oob  <= 1'b0;
            rd_tag  <= PORT_HOST;
        end else begin
            rd_pend <= any_gnt & ~sel_we;
            if (any_gnt & ~sel_we) begin
                rd_oob <= ~in_range;
                rd_tag <= e_gnt ? PORT_ENGINE : PORT_HOST;
            end
        end
    end

    always_comb begin
        rd_data  = rd_oob ? '0 : sram_q;
        h_rvalid = rd_pend & (rd_tag == PORT_HOST);
        e_rvalid = rd_pend & (rd_tag == PORT_ENGINE);
        h_rdata  = h_rvalid ? rd_data : h_hold;
        e_rdata  = e_rvalid ? rd_data : e_hold;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_hold      <= '0;
            e_hold      <= '0;
            addr_err    <= 1'b0;
            e_stall_cnt <= '0;
        end else begin
            if (h_rvalid)               h_hold   <= rd_data;
            if (e_rvalid)               e_hold   <= rd_data;
            if (any_gnt && !in_range)   addr_err <= 1'b1;
            if (e_req && !e_gnt && e_stall_cnt != '1)
                e_stall_cnt <= e_stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: stimulus pushes expected read returns, a monitor checks them.
module tb_core_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        host_lock;
    logic        h_req, h_we, e_req, e_we;
    logic [6:0]  h_addr, e_addr;
    logic [31:0] h_wdata, e_wdata;
    logic        h_gnt, h_rvalid, e_gnt, e_rvalid, addr_err;
    logic [31:0] h_rdata, e_rdata;
    logic [15:0] e_stall_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic        port;   // 0 host, 1 engine
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    core_mem_arbiter #(.DATA_BW(32), .ROWS(108), .ADDR_BW(7)) dut (
        .clk(clk), .reset(reset), .host_lock(host_lock),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .addr_err(addr_err), .e_stall_cnt(e_stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every read return must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (h_rvalid && e_rvalid) begin
            checks++; failures++;
            $display("FAIL dual_rvalid actual=both required=one (cycle %0d)", cyc);
        end
        if (h_rvalid || e_rvalid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rvalid actual=h%0b/e%0b required=none (cycle %0d)",
                         h_rvalid, e_rvalid, cyc);
            end else begin
                exp_t x;
                logic [31:0] d;
                x = sb.pop_front();
                d = e_rvalid ? e_rdata : h_rdata;
                if (e_rvalid !== x.port || d !== x.data || cyc != x.due) begin
                    failures++;
                    $display("FAIL read_return actual=port%0b data=%h cyc=%0d required=port%0b data=%h cyc=%0d",
                             e_rvalid, d, cyc, x.port, x.data, x.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            checks++; failures++;
            $display("FAIL missing_rvalid actual=none required=port%0b data=%h (cycle %0d)",
                     x.port, x.data, cyc);
        end
    end

    task automatic host(input logic req, input logic we, input logic [6:0] a, input logic [31:0] d);
        h_req = req; h_we = we; h_addr = a; h_wdata = d;
    endtask

    task automatic eng(input logic req, input logic we, input logic [6:0] a, input logic [31:0] d);
        e_req = req; e_we = we; e_addr = a; e_wdata = d;
    endtask

    // Check grants for the current inputs, register expected read returns, advance one cycle.
    task automatic step(input logic eh, input logic ee, input logic [31:0] hd, input logic [31:0] ed);
        @(negedge clk);
        check("h_gnt", {31'd0, h_gnt}, {31'd0, eh});
        check("e_gnt", {31'd0, e_gnt}, {31'd0, ee});
        if (eh && h_req && !h_we) sb.push_back('{1'b0, hd, cyc + 1});
        if (ee && e_req && !e_we) sb.push_back('{1'b1, ed, cyc + 1});
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_h_rvalid"}, {31'd0, h_rvalid}, 32'd0);
        check({tag, "_e_rvalid"}, {31'd0, e_rvalid}, 32'd0);
        check({tag, "_h_rdata"}, h_rdata, 32'd0);
        check({tag, "_e_rdata"}, e_rdata, 32'd0);
        check({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
        check({tag, "_stall"}, {16'd0, e_stall_cnt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic eh;
        reset = 1'b1; host_lock = 1'b0;
        host(0, 0, 7'd0, 32'd0);
        eng(0, 0, 7'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, no spurious grant
        @(negedge clk);
        check_reset_outputs("rst");
        step(0, 0, 0, 0);

        // Host write then read
        host(1, 1, 7'd5, 32'hDEADBEEF); step(1, 0, 0, 0);
        host(1, 0, 7'd5, 32'd0);        step(1, 0, 32'hDEADBEEF, 0);
        host(0, 0, 7'd0, 32'd0);        step(0, 0, 0, 0);
        check("h_rdata_hold", h_rdata, 32'hDEADBEEF);

        // Preload
        host(1, 1, 7'd1,   32'h11);       step(1, 0, 0, 0);
        host(1, 1, 7'd2,   32'h22);       step(1, 0, 0, 0);
        host(1, 1, 7'd3,   32'h33);       step(1, 0, 0, 0);
        host(1, 1, 7'd107, 32'hA5A50107); step(1, 0, 0, 0);
        host(0, 0, 7'd0,   32'd0);
        check("addr_err_clean", {31'd0, addr_err}, 32'd0);

        // Lock: engine starved for 10 cycles, then granted on release
        host_lock = 1'b1;
        eng(1, 0, 7'd3, 32'd0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        check("stall_lock", {16'd0, e_stall_cnt}, 32'd10);
        host_lock = 1'b0;
        step(0, 1, 0, 32'h33);
        eng(0, 0, 7'd0, 32'd0);
        step(0, 0, 0, 0);
        check("stall_after_lock", {16'd0, e_stall_cnt}, 32'd10);

        // Conflict for 4 cycles
        host(1, 0, 7'd1, 32'd0);
        eng(1, 0, 7'd2, 32'd0);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            eh = (i % 2 == 0);
`else
            eh = 1'b1;
`endif
            step(eh, !eh, 32'h11, 32'h22);
        end
        host(0, 0, 7'd0, 32'd0);
        eng(0, 0, 7'd0, 32'd0);
        step(0, 0, 0, 0);
`ifdef MEM_ARB_RR_EN
        check("stall_conflict", {16'd0, e_stall_cnt}, 32'd12);
`else
        check("stall_conflict", {16'd0, e_stall_cnt}, 32'd14);
`endif

        // Alternating back-to-back reads
        host(1, 0, 7'd1, 32'd0); step(1, 0, 32'h11, 0);
        host(0, 0, 7'd0, 32'd0);
        eng(1, 0, 7'd2, 32'd0);  step(0, 1, 0, 32'h22);
        eng(0, 0, 7'd0, 32'd0);  step(0, 0, 0, 0);

        // Out of range
        eng(1, 1, 7'd108, 32'hFFFFFFFF); step(0, 1, 0, 0);
        eng(0, 0, 7'd0, 32'd0);
        check("addr_err_set", {31'd0, addr_err}, 32'd1);
        eng(1, 0, 7'd107, 32'd0);        step(0, 1, 0, 32'hA5A50107);
        eng(0, 0, 7'd0, 32'd0);
        host(1, 0, 7'd120, 32'd0);       step(1, 0, 32'd0, 0);
        host(0, 0, 7'd0, 32'd0);         step(0, 0, 0, 0);
        check("h_rdata_oob_hold", h_rdata, 32'd0);
        check("addr_err_sticky", {31'd0, addr_err}, 32'd1);

        // host_lock rises while an engine read is in flight
        eng(1, 0, 7'd2, 32'd0);  step(0, 1, 0, 32'h22);
        host_lock = 1'b1;        step(0, 0, 0, 0);
        host_lock = 1'b0;
        eng(0, 0, 7'd0, 32'd0);  step(0, 0, 0, 0);

        // Reset on the cycle after a granted read: return discarded
        host(1, 0, 7'd5, 32'd0);
        @(negedge clk);
        check("h_gnt_pre_reset", {31'd0, h_gnt}, 32'd1);
        @(posedge clk); #1;
        host(0, 0, 7'd0, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        step(0, 0, 0, 0);

        // Contents survive reset
        host(1, 0, 7'd5, 32'd0);   step(1, 0, 32'hDEADBEEF, 0);
        host(1, 0, 7'd107, 32'd0); step(1, 0, 32'hA5A50107, 0);
        host(0, 0, 7'd0, 32'd0);
        repeat (3) step(0, 0, 0, 0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
